// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared widths, entry layout and decode helper for the write stage
package writeback_unit_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 8;
  localparam int WB_ENTRY_W = REG_ADDR_W + DATA_W;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  // Packing matches the register-file side: addr in [10:8], data in [7:0].
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order result queue with per-slot valid bits exposed for hazard decode
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            head_data,
  output logic                        full,
  output logic                        empty,
  output logic [CNT_W-1:0]            count,
  output logic [DEPTH-1:0]            entry_valid,
  output logic [DEPTH-1:0][WIDTH-1:0] entries
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            vld_next;
  logic                        do_push;
  logic                        do_pop;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign head_data   = mem[rd_ptr];
  assign entry_valid = vld;
  assign entries     = mem;

  // Clear before set so a push into the slot just vacated stays marked valid.
  always_comb begin
    vld_next = vld;
    if (do_pop) vld_next[rd_ptr] = 1'b0;
    if (do_push) vld_next[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      vld <= vld_next;
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - arbitrates ALU/load results into the FIFO and drives the register-file write port
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  wb_hold,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0]     rf_write_data,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [CNT_W-1:0]      fifo_count,
  output logic [7:0]            r0_drop_count
);

  logic                             full;
  logic                             empty;
  logic                             mem_fire;
  logic                             alu_fire;
  logic                             accept;
  logic                             push;
  logic                             drop;
  logic                             pop;
  wb_entry_t                        in_entry;
  wb_entry_t                        head;
  logic [WB_ENTRY_W-1:0]            head_data;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0][WB_ENTRY_W-1:0] entries;
  logic [NUM_REGS-1:0]              mask;

  // Readiness looks only at occupancy, never at hold or a same-cycle pop.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign mem_fire  = mem_valid && mem_ready;
  assign alu_fire  = alu_valid && alu_ready;
  assign accept    = mem_fire || alu_fire;

  always_comb begin
    in_entry = '0;
    if (mem_fire) begin
      in_entry.addr = mem_addr;
      in_entry.data = mem_data;
    end else if (alu_fire) begin
      in_entry.addr = alu_addr;
      in_entry.data = alu_data;
    end
  end

  // R0 is hard-wired zero: complete the handshake but never queue it.
  assign push = accept && (in_entry.addr != '0);
  assign drop = accept && (in_entry.addr == '0);
  assign pop  = !empty && !wb_hold;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WB_ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_data   (in_entry),
    .pop         (pop),
    .head_data   (head_data),
    .full        (full),
    .empty       (empty),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  assign head            = wb_entry_t'(head_data);
  assign rf_write_enable = pop;
  assign rf_write_addr   = empty ? '0 : head.addr;
  assign rf_write_data   = empty ? '0 : head.data;

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) mask = mask | reg_onehot(entries[i][WB_ENTRY_W-1:DATA_W]);
    end
  end

  assign pending_mask = {mask[NUM_REGS-1:1], 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_drop_count <= '0;
    end else if (drop && (r0_drop_count != 8'hFF)) begin
      r0_drop_count <= r0_drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;

  logic       clk;
  logic       rst;
  logic       alu_valid;
  logic       alu_ready;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       mem_valid;
  logic       mem_ready;
  logic [2:0] mem_addr;
  logic [7:0] mem_data;
  logic       wb_hold;
  logic       rf_write_enable;
  logic [2:0] rf_write_addr;
  logic [7:0] rf_write_data;
  logic [7:0] pending_mask;
  logic [2:0] fifo_count;
  logic [7:0] r0_drop_count;

  int vectors = 0;
  int errors  = 0;

  writeback_unit #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_addr        (alu_addr),
    .alu_data        (alu_data),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .wb_hold         (wb_hold),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .pending_mask    (pending_mask),
    .fifo_count      (fifo_count),
    .r0_drop_count   (r0_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Producers must keep a refused request stable until it is accepted.
  assert property (@(posedge clk) disable iff (rst)
    (alu_valid && !alu_ready) |=> (alu_valid && $stable(alu_addr) && $stable(alu_data)));
  assert property (@(posedge clk) disable iff (rst)
    (mem_valid && !mem_ready) |=> (mem_valid && $stable(mem_addr) && $stable(mem_data)));

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0; wb_hold = 0;
    step(); step();
    vectors++;
    if (rf_write_enable !== 1'b0 || pending_mask !== 8'h00 || fifo_count !== 3'd0 ||
        r0_drop_count !== 8'h00 || rf_write_addr !== 3'd0 || rf_write_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: we=%b mask=0x%0h cnt=%0d drop=%0d addr=%0d data=0x%0h expected all 0",
               rf_write_enable, pending_mask, fifo_count, r0_drop_count, rf_write_addr, rf_write_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_midrun();
    wb_hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1'b1; alu_addr = 3'(i); alu_data = 8'(8'h40 + i);
      step();
    end
    alu_valid = 1'b0;
    #1;
    chk("midrun_pre_count", 8'(fifo_count), 8'd3);
    chk("midrun_pre_mask", pending_mask, 8'h0E);
    rst = 1'b1;
    #1;
    chk("midrun_async_count", 8'(fifo_count), 8'd0);
    chk("midrun_async_mask", pending_mask, 8'h00);
    chk("midrun_async_we", 8'(rf_write_enable), 8'd0);
    step();
    rst = 1'b0; wb_hold = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("midrun_no_stale_we", 8'(rf_write_enable), 8'd0);
      step();
    end
  endtask

  task automatic test_latency();
    alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 8'h5A;
    #1;
    chk("lat_alu_ready", 8'(alu_ready), 8'd1);
    step();
    alu_valid = 1'b0;
    #1;
    chk("lat_we", 8'(rf_write_enable), 8'd1);
    chk("lat_addr", 8'(rf_write_addr), 8'd3);
    chk("lat_data", rf_write_data, 8'h5A);
    chk("lat_mask", pending_mask, 8'h08);
    step();
    chk("lat_we_after", 8'(rf_write_enable), 8'd0);
    chk("lat_mask_after", pending_mask, 8'h00);
    chk("lat_count_after", 8'(fifo_count), 8'd0);
  endtask

  task automatic test_priority();
    mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 8'h11;
    alu_valid = 1'b1; alu_addr = 3'd4; alu_data = 8'h22;
    #1;
    chk("prio_mem_ready", 8'(mem_ready), 8'd1);
    chk("prio_alu_ready", 8'(alu_ready), 8'd0);
    step();
    mem_valid = 1'b0;
    #1;
    chk("prio_alu_ready2", 8'(alu_ready), 8'd1);
    chk("prio_first_we", 8'(rf_write_enable), 8'd1);
    chk("prio_first_addr", 8'(rf_write_addr), 8'd2);
    chk("prio_first_data", rf_write_data, 8'h11);
    step();
    alu_valid = 1'b0;
    #1;
    chk("prio_second_we", 8'(rf_write_enable), 8'd1);
    chk("prio_second_addr", 8'(rf_write_addr), 8'd4);
    chk("prio_second_data", rf_write_data, 8'h22);
    step();
    chk("prio_idle_we", 8'(rf_write_enable), 8'd0);
  endtask

  task automatic test_fill_hold();
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1; alu_addr = 3'(i); alu_data = 8'(i);
      step();
    end
    alu_valid = 1'b0;
    #1;
    chk("fill_count", 8'(fifo_count), 8'd4);
    chk("fill_alu_ready", 8'(alu_ready), 8'd0);
    chk("fill_mem_ready", 8'(mem_ready), 8'd0);
    chk("fill_mask", pending_mask, 8'h1E);
    chk("fill_we_held", 8'(rf_write_enable), 8'd0);
    step();
    chk("fill_frozen_count", 8'(fifo_count), 8'd4);
    wb_hold = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_we", 8'(rf_write_enable), 8'd1);
      chk("drain_addr", 8'(rf_write_addr), 8'(k + 1));
      chk("drain_data", rf_write_data, 8'(k + 1));
      chk("drain_count", 8'(fifo_count), 8'(4 - k));
      step();
    end
    chk("drain_final_count", 8'(fifo_count), 8'd0);
    chk("drain_final_we", 8'(rf_write_enable), 8'd0);
  endtask

  task automatic test_same_reg();
    wb_hold = 1'b1;
    alu_valid = 1'b1; alu_addr = 3'd5; alu_data = 8'hAA;
    step();
    alu_data = 8'hBB;
    step();
    alu_valid = 1'b0;
    #1;
    chk("same_mask_both", pending_mask, 8'h20);
    chk("same_count", 8'(fifo_count), 8'd2);
    wb_hold = 1'b0;
    #1;
    chk("same_first_data", rf_write_data, 8'hAA);
    step();
    chk("same_second_we", 8'(rf_write_enable), 8'd1);
    chk("same_second_addr", 8'(rf_write_addr), 8'd5);
    chk("same_second_data", rf_write_data, 8'hBB);
    chk("same_mask_one", pending_mask, 8'h20);
    step();
    chk("same_mask_clear", pending_mask, 8'h00);
    chk("same_we_idle", 8'(rf_write_enable), 8'd0);
  endtask

  task automatic test_r0_filter();
    int we_seen;
    int cnt_bad;
    we_seen = 0;
    cnt_bad = 0;
    alu_valid = 1'b1; alu_addr = 3'd0;
    for (int i = 0; i < 260; i++) begin
      alu_data = 8'(i);
      step();
      if (rf_write_enable !== 1'b0) we_seen++;
      if (fifo_count !== 3'd0) cnt_bad++;
      if (i == 0) chk("r0_drop_first", r0_drop_count, 8'd1);
      if (i == 253) chk("r0_drop_254", r0_drop_count, 8'd254);
    end
    alu_valid = 1'b0;
    #1;
    chk("r0_no_writes", 8'(we_seen), 8'd0);
    chk("r0_count_zero", 8'(cnt_bad), 8'd0);
    chk("r0_drop_sat", r0_drop_count, 8'd255);
    chk("r0_mask", pending_mask, 8'h00);
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_latency();
    test_priority();
    test_fill_hold();
    test_same_reg();
    test_r0_filter();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
